// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit between the EX/MEM register and a
// word-wide synchronous data memory. Runs read-modify-write for sb/sh, extends
// load results and freezes upstream stages while an access is in flight.
// Optional feature: define LSU_ALIGN_CHECK_EN to trap misaligned and
// out-of-range accesses (exc pulse, no DM access). Without it, low address
// bits beyond the access size are ignored and the word address wraps.
module mem_stage_lsu #(
  parameter int unsigned AW   = 12,
  parameter logic [31:0] BASE = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [2:0]    op,
  input  logic [31:0]   addr,
  input  logic [31:0]   wdata,
  output logic          rsp_valid,
  output logic [31:0]   rdata,
  output logic          stall,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic          exc
);

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LB  = 3'b001;
  localparam logic [2:0] OP_LBU = 3'b010;
  localparam logic [2:0] OP_LH  = 3'b011;
  localparam logic [2:0] OP_LHU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SB  = 3'b110;
  localparam logic [2:0] OP_SH  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_CAP  = 2'b10,
    ST_WR   = 2'b11
  } state_t;

  state_t        state_r;
  logic [2:0]    op_r;
  logic [1:0]    lo_r;
  logic [31:0]   wdata_r;
  logic [31:0]   word_r;
  logic [AW-1:0] mem_addr_r;
  logic          mem_en_r;
  logic          mem_we_r;
  logic          rsp_valid_r;
  logic          exc_r;
  logic          req_ready_r;

  logic [31:0]   offset_s;
  logic          bad_s;
  logic [31:0]   rdata_s;
  logic [31:0]   mem_wdata_s;
  logic          unused_s;

  // Sub-word stores must read the old word first.
  function automatic logic is_rmw(input logic [2:0] f_op);
    return (f_op == OP_SB) || (f_op == OP_SH);
  endfunction

  // Select and extend the addressed byte/half out of a DM word.
  function automatic logic [31:0] load_extract(input logic [2:0] f_op,
                                               input logic [1:0] f_lo,
                                               input logic [31:0] f_word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = f_word[{f_lo, 3'b000} +: 8];
    h = f_word[{f_lo[1], 4'b0000} +: 16];
    case (f_op)
      OP_LW:   r = f_word;
      OP_LB:   r = {{24{b[7]}}, b};
      OP_LBU:  r = {24'h00_0000, b};
      OP_LH:   r = {{16{h[15]}}, h};
      OP_LHU:  r = {16'h0000, h};
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  // Merge store data into the captured word; sw replaces the whole word.
  function automatic logic [31:0] store_merge(input logic [2:0] f_op,
                                              input logic [1:0] f_lo,
                                              input logic [31:0] f_old,
                                              input logic [31:0] f_wd);
    logic [31:0] m;
    m = f_old;
    case (f_op)
      OP_SB:   m[{f_lo, 3'b000} +: 8] = f_wd[7:0];
      OP_SH:   m[{f_lo[1], 4'b0000} +: 16] = f_wd[15:0];
      OP_SW:   m = f_wd;
      default: m = f_old;
    endcase
    return m;
  endfunction

  assign offset_s = addr - BASE;
  // Offset bits outside the word index only matter to the range check.
  assign unused_s = ^{offset_s[31:AW+2], offset_s[1:0]};

`ifdef LSU_ALIGN_CHECK_EN
  // Flag accesses misaligned for their size or outside the DM window.
  always_comb begin
    bad_s = 1'b0;
    case (op)
      OP_LW, OP_SW:         bad_s = (addr[1:0] != 2'b00);
      OP_LH, OP_LHU, OP_SH: bad_s = addr[0];
      default:              bad_s = 1'b0;
    endcase
    if (offset_s[31:AW+2] != {(30-AW){1'b0}}) begin
      bad_s = 1'b1;
    end else begin
      bad_s = bad_s;
    end
  end
  assign exc = exc_r;
`else
  assign bad_s = 1'b0;
  assign exc   = 1'b0;
`endif

  // Access sequencer: latches the request and drives DM control from registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      op_r        <= 3'b000;
      lo_r        <= 2'b00;
      wdata_r     <= 32'h0000_0000;
      word_r      <= 32'h0000_0000;
      mem_addr_r  <= {AW{1'b0}};
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      rsp_valid_r <= 1'b0;
      exc_r       <= 1'b0;
      req_ready_r <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_valid) begin
            op_r        <= op;
            lo_r        <= addr[1:0];
            wdata_r     <= wdata;
            mem_addr_r  <= offset_s[AW+1:2];
            req_ready_r <= 1'b0;
            if (bad_s) begin
              state_r     <= ST_CAP;
              exc_r       <= 1'b1;
              rsp_valid_r <= 1'b1;
            end else if (op == OP_SW) begin
              state_r     <= ST_WR;
              mem_en_r    <= 1'b1;
              mem_we_r    <= 1'b1;
              rsp_valid_r <= 1'b1;
            end else begin
              state_r  <= ST_RD;
              mem_en_r <= 1'b1;
            end
          end
        end
        ST_RD: begin
          state_r     <= ST_CAP;
          mem_en_r    <= 1'b0;
          rsp_valid_r <= !is_rmw(op_r);
        end
        ST_CAP: begin
          word_r <= mem_rdata;
          exc_r  <= 1'b0;
          if (is_rmw(op_r) && !exc_r) begin
            state_r     <= ST_WR;
            mem_en_r    <= 1'b1;
            mem_we_r    <= 1'b1;
            rsp_valid_r <= 1'b1;
          end else begin
            state_r     <= ST_IDLE;
            rsp_valid_r <= 1'b0;
            req_ready_r <= 1'b1;
          end
        end
        ST_WR: begin
          state_r     <= ST_IDLE;
          mem_en_r    <= 1'b0;
          mem_we_r    <= 1'b0;
          rsp_valid_r <= 1'b0;
          req_ready_r <= 1'b1;
        end
        default: begin
          state_r     <= ST_IDLE;
          mem_en_r    <= 1'b0;
          mem_we_r    <= 1'b0;
          rsp_valid_r <= 1'b0;
          exc_r       <= 1'b0;
          req_ready_r <= 1'b1;
        end
      endcase
    end
  end

  // Load result comes straight from the DM read word in the CAP response cycle.
  always_comb begin
    rdata_s = 32'h0000_0000;
    if ((state_r == ST_CAP) && rsp_valid_r && !exc_r) begin
      rdata_s = load_extract(op_r, lo_r, mem_rdata);
    end else begin
      rdata_s = 32'h0000_0000;
    end
  end

  // Write word is built from registered request data and the captured word.
  always_comb begin
    mem_wdata_s = 32'h0000_0000;
    if (state_r == ST_WR) begin
      mem_wdata_s = store_merge(op_r, lo_r, word_r, wdata_r);
    end else begin
      mem_wdata_s = 32'h0000_0000;
    end
  end

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rdata     = rdata_s;
  assign mem_en    = mem_en_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_s;
  // Upstream may advance in the response cycle so the next request is ready.
  assign stall     = req_ready_r ? req_valid : !rsp_valid_r;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu with a behavioural synchronous DM.
module tb_mem_stage_lsu;

  localparam int AW = 12;
  localparam logic [2:0] LW = 3'b000, LB = 3'b001, LBU = 3'b010, LH = 3'b011;
  localparam logic [2:0] LHU = 3'b100, SW = 3'b101, SB = 3'b110, SH = 3'b111;

  typedef struct {
    logic [31:0] rdata;
    logic        exc;
    int          lat;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [2:0]    op;
  logic [31:0]   addr;
  logic [31:0]   wdata;
  logic          rsp_valid;
  logic [31:0]   rdata;
  logic          stall;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          exc;

  logic          pre_we;
  logic [AW-1:0] pre_addr;
  logic [31:0]   pre_data;
  logic [31:0]   dm [0:(1<<AW)-1];

  int   n_cmp;
  int   n_fail;
  int   acc_cnt = 0;
  int   we_cnt = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  mem_stage_lsu #(.AW(AW), .BASE(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .op(op), .addr(addr), .wdata(wdata), .rsp_valid(rsp_valid), .rdata(rdata),
    .stall(stall), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .exc(exc)
  );

  // Synchronous DM with a bench-side preload port.
  always @(posedge clk) begin
    if (pre_we) dm[pre_addr] <= pre_data;
    else if (mem_en) begin
      if (mem_we) dm[mem_addr] <= mem_wdata;
      else        mem_rdata <= dm[mem_addr];
    end
  end

  // Count accepted requests and DM write cycles.
  always @(posedge clk) begin
    if (reset && req_valid && req_ready) acc_cnt <= acc_cnt + 1;
    if (mem_we) we_cnt <= we_cnt + 1;
  end

  task automatic poke(input int idx, input logic [31:0] d);
    pre_we = 1'b1; pre_addr = AW'(idx); pre_data = d;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  // Issue one request and observe its response (no checking here).
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] wd,
                        output logic to, output logic sbad, output int lat,
                        output logic [31:0] rd, output logic ex, output logic we,
                        output logic [31:0] wdo, output int en_cnt);
    to = 1'b1; sbad = 1'b0; lat = 1; rd = 32'h0; ex = 1'b0; we = 1'b0; wdo = 32'h0; en_cnt = 0;
    req_valid = 1'b1; op = o; addr = a; wdata = wd;
    #1;
    if (!(req_ready && stall)) sbad = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      en_cnt += int'(mem_en);
      if (rsp_valid) begin
        rd = rdata; ex = exc; we = mem_we; wdo = mem_wdata; to = 1'b0;
        if (stall) sbad = 1'b1;
        break;
      end
      if (!stall) sbad = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({req_ready, rsp_valid, stall, mem_en, mem_we, exc} !== 6'b100000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b required 100000", {req_ready, rsp_valid, stall, mem_en, mem_we, exc});
    end
    n_cmp++;
    if ({rdata, mem_wdata, mem_addr} !== {64'h0, {AW{1'b0}}}) begin
      n_fail++;
      $display("FAIL reset_data: rdata=%h mem_wdata=%h mem_addr=%h required all 0", rdata, mem_wdata, mem_addr);
    end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_sw_lw();
    exp_t e; logic to, sbad, ex, we; int lat, en; logic [31:0] rd, wdo;
    sb_q.push_back('{32'h0, 1'b0, 1});
    run_op(SW, 32'h10, 32'h1234_5678, to, sbad, lat, rd, ex, we, wdo, en);
    e = sb_q.pop_front();
    n_cmp++;
    if ({to, sbad, ex, 4'(lat), rd} !== {1'b0, 1'b0, e.exc, 4'(e.lat), e.rdata}) begin
      n_fail++;
      $display("FAIL sw_rsp: got to=%b stall_err=%b exc=%b lat=%0d rdata=%h required exc=%b lat=%0d rdata=%h",
               to, sbad, ex, lat, rd, e.exc, e.lat, e.rdata);
    end
    n_cmp++;
    if ({we, wdo, dm[4]} !== {1'b1, 32'h1234_5678, 32'h1234_5678}) begin
      n_fail++;
      $display("FAIL sw_write: we=%b mem_wdata=%h dm=%h required 1 12345678 12345678", we, wdo, dm[4]);
    end
    sb_q.push_back('{32'h1234_5678, 1'b0, 2});
    run_op(LW, 32'h10, 32'h0, to, sbad, lat, rd, ex, we, wdo, en);
    e = sb_q.pop_front();
    n_cmp++;
    if ({to, sbad, ex, 4'(lat), rd} !== {1'b0, 1'b0, e.exc, 4'(e.lat), e.rdata}) begin
      n_fail++;
      $display("FAIL lw_rsp: got to=%b stall_err=%b exc=%b lat=%0d rdata=%h required exc=%b lat=%0d rdata=%h",
               to, sbad, ex, lat, rd, e.exc, e.lat, e.rdata);
    end
  endtask

  task automatic test_sb_rmw();
    exp_t e; logic to, sbad, ex, we; int lat, en; logic [31:0] rd, wdo;
    sb_q.push_back('{32'h0, 1'b0, 3});
    run_op(SB, 32'h12, 32'h0000_00AB, to, sbad, lat, rd, ex, we, wdo, en);
    e = sb_q.pop_front();
    n_cmp++;
    if ({to, sbad, ex, 4'(lat), rd} !== {1'b0, 1'b0, e.exc, 4'(e.lat), e.rdata}) begin
      n_fail++;
      $display("FAIL sb_rsp: got to=%b stall_err=%b exc=%b lat=%0d rdata=%h required exc=%b lat=%0d rdata=%h",
               to, sbad, ex, lat, rd, e.exc, e.lat, e.rdata);
    end
    n_cmp++;
    if ({we, wdo, dm[4]} !== {1'b1, 32'h12AB_5678, 32'h12AB_5678}) begin
      n_fail++;
      $display("FAIL sb_merge: we=%b mem_wdata=%h dm=%h required 1 12ab5678 12ab5678", we, wdo, dm[4]);
    end
  endtask

  task automatic test_load_ext();
    logic [2:0]  ops  [4] = '{LB, LBU, LH, LHU};
    logic [31:0] adrs [4] = '{32'h17, 32'h17, 32'h16, 32'h16};
    logic [31:0] exps [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_80FF};
    exp_t e; logic to, sbad, ex, we; int lat, en; logic [31:0] rd, wdo;
    poke(5, 32'h80FF_0000);
    for (int i = 0; i < 4; i++) begin
      sb_q.push_back('{exps[i], 1'b0, 2});
      run_op(ops[i], adrs[i], 32'h0, to, sbad, lat, rd, ex, we, wdo, en);
      e = sb_q.pop_front();
      n_cmp++;
      if ({to, sbad, ex, 4'(lat), rd} !== {1'b0, 1'b0, e.exc, 4'(e.lat), e.rdata}) begin
        n_fail++;
        $display("FAIL load_ext[%0d]: got to=%b stall_err=%b exc=%b lat=%0d rdata=%h required exc=%b lat=%0d rdata=%h",
                 i, to, sbad, ex, lat, rd, e.exc, e.lat, e.rdata);
      end
    end
  endtask

  task automatic test_align();
    exp_t e; logic to, sbad, ex, we; int lat, en; logic [31:0] rd, wdo; int exp_en;
`ifdef LSU_ALIGN_CHECK_EN
    sb_q.push_back('{32'h0, 1'b1, 1});
    sb_q.push_back('{32'h0, 1'b1, 1});
    exp_en = 0;
`else
    sb_q.push_back('{32'h12AB_5678, 1'b0, 2});
    sb_q.push_back('{32'h12AB_5678, 1'b0, 2});
    exp_en = 1;
`endif
    run_op(LW, 32'h13, 32'h0, to, sbad, lat, rd, ex, we, wdo, en);
    e = sb_q.pop_front();
    n_cmp++;
    if ({to, sbad, ex, 4'(lat), rd} !== {1'b0, 1'b0, e.exc, 4'(e.lat), e.rdata}) begin
      n_fail++;
      $display("FAIL misalign_lw: got to=%b stall_err=%b exc=%b lat=%0d rdata=%h required exc=%b lat=%0d rdata=%h",
               to, sbad, ex, lat, rd, e.exc, e.lat, e.rdata);
    end
    n_cmp++;
    if (en !== exp_en) begin
      n_fail++;
      $display("FAIL misalign_mem_en: got %0d enabled cycles required %0d", en, exp_en);
    end
    run_op(LW, 32'h4010, 32'h0, to, sbad, lat, rd, ex, we, wdo, en);
    e = sb_q.pop_front();
    n_cmp++;
    if ({to, sbad, ex, 4'(lat), rd} !== {1'b0, 1'b0, e.exc, 4'(e.lat), e.rdata}) begin
      n_fail++;
      $display("FAIL range_lw: got to=%b stall_err=%b exc=%b lat=%0d rdata=%h required exc=%b lat=%0d rdata=%h",
               to, sbad, ex, lat, rd, e.exc, e.lat, e.rdata);
    end
  endtask

  task automatic test_back_to_back();
    int a0; logic bad; logic done;
    poke(12, 32'h5555_5555);
    a0 = acc_cnt; bad = 1'b0; done = 1'b0;
    req_valid = 1'b1; op = SH; addr = 32'h30; wdata = 32'h0000_CAFE;
    @(posedge clk); #1;
    for (int k = 1; k <= 3; k++) begin
      #1;
      if (k < 3) begin
        if (!(stall && !rsp_valid && !req_ready)) bad = 1'b1;
      end else begin
        if (!(rsp_valid && !stall && !req_ready)) bad = 1'b1;
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (bad !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_busy: stall/ready/rsp sequence error=%b required 0", bad);
    end
    n_cmp++;
    if (acc_cnt - a0 !== 1) begin
      n_fail++;
      $display("FAIL b2b_no_queue: got %0d accepts required 1", acc_cnt - a0);
    end
    #1;
    n_cmp++;
    if ({req_ready, stall} !== 2'b11) begin
      n_fail++;
      $display("FAIL b2b_ready: got ready,stall=%b required 11", {req_ready, stall});
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_cmp++;
    if (acc_cnt - a0 !== 2) begin
      n_fail++;
      $display("FAIL b2b_second: got %0d accepts required 2", acc_cnt - a0);
    end
    for (int k = 0; k < 8; k++) begin
      #1;
      if (rsp_valid) begin done = 1'b1; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({done, dm[12]} !== {1'b1, 32'h5555_CAFE}) begin
      n_fail++;
      $display("FAIL b2b_data: done=%b dm=%h required 1 5555cafe", done, dm[12]);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e; logic to, sbad, ex, we; int lat, en; logic [31:0] rd, wdo; int w0;
    poke(8, 32'h1111_2222);
    w0 = we_cnt;
    req_valid = 1'b1; op = SH; addr = 32'h22; wdata = 32'h0000_BEEF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({req_ready, rsp_valid, mem_en, mem_we, stall} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_mid_ctrl: got %b required 10000", {req_ready, rsp_valid, mem_en, mem_we, stall});
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({dm[8], 8'(we_cnt - w0)} !== {32'h1111_2222, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_mid_word: dm=%h writes=%0d required 11112222 0", dm[8], we_cnt - w0);
    end
    sb_q.push_back('{32'h0, 1'b0, 3});
    run_op(SH, 32'h22, 32'h0000_BEEF, to, sbad, lat, rd, ex, we, wdo, en);
    e = sb_q.pop_front();
    n_cmp++;
    if ({to, sbad, ex, 4'(lat), rd, dm[8]} !== {1'b0, 1'b0, e.exc, 4'(e.lat), e.rdata, 32'hBEEF_2222}) begin
      n_fail++;
      $display("FAIL sh_after_reset: got to=%b stall_err=%b exc=%b lat=%0d rdata=%h dm=%h required lat=%0d dm=beef2222",
               to, sbad, ex, lat, rd, dm[8], e.lat);
    end
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; op = 3'b000; addr = 32'h0; wdata = 32'h0;
    pre_we = 1'b0; pre_addr = {AW{1'b0}}; pre_data = 32'h0;
    n_cmp = 0; n_fail = 0;
    test_reset();
    test_sw_lw();
    test_sb_rmw();
    test_load_ext();
    test_align();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
